sdram_cpu_port: RTL and testbench

//  Initiator for one sdram controller port, using the req/ack toggle protocol.

---
 rtl/sdram_cpu_port_if.sv | 30 +++
 rtl/sdram_cpu_port.sv | 160 ++++++++++++++++
 tb/tb_sdram_cpu_port.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cpu_port_if.sv
// rtl/sdram_cpu_port_if.sv - CPU strobe bus and sdram req/ack toggle port signals
interface sdram_cpu_port_if #(
    parameter int AW = 16
);
    logic          flush;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_rdy;
    logic          cpu_wait;
    logic          sd_req;
    logic          sd_ack;
    logic          sd_wr;
    logic [23:0]   sd_addr;
    logic [15:0]   sd_din;
    logic [15:0]   sd_dout;
    logic [1:0]    sd_be;

    modport master (
        input  flush, cpu_rd, cpu_wr, cpu_addr, cpu_din, sd_ack, sd_dout,
        output cpu_dout, cpu_rdy, cpu_wait, sd_req, sd_wr, sd_addr, sd_din, sd_be
    );

    modport slave (
        output flush, cpu_rd, cpu_wr, cpu_addr, cpu_din, sd_ack, sd_dout,
        input  cpu_dout, cpu_rdy, cpu_wait, sd_req, sd_wr, sd_addr, sd_din, sd_be
    );
endinterface

// File: rtl/sdram_cpu_port.sv
// rtl/sdram_cpu_port.sv - 8-bit CPU strobe bus to 16-bit sdram toggle port
// One-word read line buffer with write-through, plus a 1-deep posted-write slot.
module sdram_cpu_port #(
    parameter int          AW   = 16,
    parameter logic [23:0] BASE = 24'h000000
) (
    input  logic             clk,
    input  logic             reset,
    sdram_cpu_port_if.master bus
);
    typedef enum logic [1:0] {SYNC, IDLE, RD, WR} state_t;

    state_t        r_state;
    logic          r_sd_req;
    logic          r_sd_wr;
    logic [23:0]   r_sd_addr;
    logic [15:0]   r_sd_din;
    logic [1:0]    r_sd_be;
    logic [7:0]    r_cpu_dout;
    logic          r_cpu_rdy;
    logic          r_cpu_wait;
    logic [15:0]   r_line;
    logic [23:0]   r_tag;
    logic          r_valid;
    logic          r_nocache;
    logic          r_rd_hi;
    logic          r_pend;
    logic          r_pend_wr;
    logic          r_pend_rd;
    logic [AW-1:0] r_pend_addr;
    logic [7:0]    r_pend_din;

    logic          w_done;
    logic          w_cpu_wr;
    logic          w_cpu_rd;
    logic          w_s_wr;
    logic          w_s_rd;
    logic [AW-1:0] w_s_addr;
    logic [7:0]    w_s_din;
    logic [23:0]   w_s_waddr;
    logic          w_hit;
    logic [7:0]    w_hit_byte;

    assign w_done   = (bus.sd_ack == r_sd_req);
    assign w_cpu_wr = bus.cpu_wr & ~r_cpu_wait;
    assign w_cpu_rd = bus.cpu_rd & ~bus.cpu_wr & ~r_cpu_wait;

    // In IDLE a parked strobe from the slot takes the place of the CPU strobe
    assign w_s_wr     = r_pend ? r_pend_wr   : w_cpu_wr;
    assign w_s_rd     = r_pend ? r_pend_rd   : w_cpu_rd;
    assign w_s_addr   = r_pend ? r_pend_addr : bus.cpu_addr;
    assign w_s_din    = r_pend ? r_pend_din  : bus.cpu_din;
    assign w_s_waddr  = BASE + 24'(w_s_addr[AW-1:1]);
    assign w_hit      = r_valid && (r_tag == w_s_waddr);
    assign w_hit_byte = w_s_addr[0] ? r_line[15:8] : r_line[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SYNC;
            r_sd_req    <= 1'b0;
            r_sd_wr     <= 1'b0;
            r_sd_addr   <= 24'h0;
            r_sd_din    <= 16'h0;
            r_sd_be     <= 2'b00;
            r_cpu_dout  <= 8'h0;
            r_cpu_rdy   <= 1'b0;
            r_cpu_wait  <= 1'b1;
            r_line      <= 16'h0;
            r_tag       <= 24'h0;
            r_valid     <= 1'b0;
            r_nocache   <= 1'b0;
            r_rd_hi     <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_wr   <= 1'b0;
            r_pend_rd   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_din  <= 8'h0;
        end else begin
            r_cpu_rdy <= 1'b0;
            if (bus.flush) r_valid <= 1'b0;
            case (r_state)
                SYNC: begin
                    // Controller may not have been reset with us: adopt its toggle phase
                    r_sd_req   <= bus.sd_ack;
                    r_cpu_wait <= 1'b0;
                    r_state    <= IDLE;
                end
                IDLE: begin
                    if (w_s_wr) begin
                        r_sd_req   <= ~r_sd_req;
                        r_sd_wr    <= 1'b1;
                        r_sd_addr  <= w_s_waddr;
                        r_sd_din   <= {w_s_din, w_s_din};
                        r_sd_be    <= w_s_addr[0] ? 2'b10 : 2'b01;
                        if (w_hit) begin
                            if (w_s_addr[0]) r_line[15:8] <= w_s_din;
                            else             r_line[7:0]  <= w_s_din;
                        end
                        r_cpu_wait <= 1'b0;
                        r_pend     <= 1'b0;
                        r_state    <= WR;
                    end else if (w_s_rd) begin
                        r_pend <= 1'b0;
                        if (w_hit) begin
                            r_cpu_dout <= w_hit_byte;
                            r_cpu_rdy  <= 1'b1;
                            r_cpu_wait <= 1'b0;
                        end else begin
                            r_sd_req   <= ~r_sd_req;
                            r_sd_wr    <= 1'b0;
                            r_sd_addr  <= w_s_waddr;
                            r_sd_be    <= 2'b11;
                            r_rd_hi    <= w_s_addr[0];
                            r_nocache  <= bus.flush;
                            r_cpu_wait <= 1'b1;
                            r_state    <= RD;
                        end
                    end
                end
                RD: begin
                    if (w_done) begin
                        r_cpu_dout <= r_rd_hi ? bus.sd_dout[15:8] : bus.sd_dout[7:0];
                        r_cpu_rdy  <= 1'b1;
                        r_cpu_wait <= 1'b0;
                        r_state    <= IDLE;
                        // A flush anywhere in the fill window means the data may be stale
                        if (!(r_nocache || bus.flush)) begin
                            r_line  <= bus.sd_dout;
                            r_tag   <= r_sd_addr;
                            r_valid <= 1'b1;
                        end
                    end else if (bus.flush) begin
                        r_nocache <= 1'b1;
                    end
                end
                WR: begin
                    if (w_cpu_wr || w_cpu_rd) begin
                        r_pend      <= 1'b1;
                        r_pend_wr   <= w_cpu_wr;
                        r_pend_rd   <= w_cpu_rd;
                        r_pend_addr <= bus.cpu_addr;
                        r_pend_din  <= bus.cpu_din;
                        r_cpu_wait  <= 1'b1;
                    end
                    if (w_done) r_state <= IDLE;
                end
                default: r_state <= SYNC;
            endcase
        end
    end

    assign bus.sd_req   = r_sd_req;
    assign bus.sd_wr    = r_sd_wr;
    assign bus.sd_addr  = r_sd_addr;
    assign bus.sd_din   = r_sd_din;
    assign bus.sd_be    = r_sd_be;
    assign bus.cpu_dout = r_cpu_dout;
    assign bus.cpu_rdy  = r_cpu_rdy;
    assign bus.cpu_wait = r_cpu_wait;
endmodule

// File: tb/tb_sdram_cpu_port.sv
// tb/tb_sdram_cpu_port.sv - scoreboard bench for sdram_cpu_port
// Behavioural toggle controller with fixed latency plus a byte-level reference memory.
`timescale 1ns/1ps
module tb_sdram_cpu_port;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdram_cpu_port_if #(.AW(16)) bus ();
    sdram_cpu_port_if #(.AW(16)) bus2 ();

    sdram_cpu_port #(.AW(16), .BASE(24'h000000)) dut (.clk(clk), .reset(reset), .bus(bus));
    sdram_cpu_port #(.AW(16), .BASE(24'hFFFFF0)) dut_wrap (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [15:0] din;
        logic [1:0]  be;
    } req_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  din;
        int          reqs;
        logic        last_wr;
    } vec_t;

    int          n_checks = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    req_t        req_log [$];
    logic [15:0] mem [logic [23:0]];
    logic [7:0]  ref_mem [logic [15:0]];
    bit          ctl_en = 1'b0;
    bit          ctl_busy = 1'b0;
    int          ctl_cnt = 0;
    req_t        ctl_cur;
    logic        ack_r = 1'b1;
    logic [15:0] dout_r = 16'h0;

    assign bus.sd_ack   = ack_r;
    assign bus.sd_dout  = dout_r;
    assign bus2.sd_ack  = 1'b0;
    assign bus2.sd_dout = 16'h0;
    assign bus2.flush   = 1'b0;
    assign bus2.cpu_wr  = 1'b0;
    assign bus2.cpu_din = 8'h0;

    function automatic logic [15:0] init_word(input logic [23:0] w);
        return {w[7:0] ^ 8'h5A, w[7:0] + 8'h11};
    endfunction

    function automatic logic [15:0] mem_rd(input logic [23:0] w);
        return mem.exists(w) ? mem[w] : init_word(w);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        logic [15:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word({9'h0, a[15:1]});
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin : ctl
        logic [15:0] w;
        if (!ctl_busy && ctl_en && !reset && bus.sd_req != bus.sd_ack) begin
            ctl_busy = 1'b1;
            ctl_cnt  = LAT;
            ctl_cur  = '{wr: bus.sd_wr, addr: bus.sd_addr, din: bus.sd_din, be: bus.sd_be};
            req_log.push_back(ctl_cur);
        end
        if (ctl_busy) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                if (ctl_cur.wr) begin
                    w = mem_rd(ctl_cur.addr);
                    if (ctl_cur.be[0]) w[7:0]  = ctl_cur.din[7:0];
                    if (ctl_cur.be[1]) w[15:8] = ctl_cur.din[15:8];
                    mem[ctl_cur.addr] = w;
                end else begin
                    dout_r <= mem_rd(ctl_cur.addr);
                end
                ack_r <= ~ack_r;
                ctl_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (!reset && bus.cpu_rdy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL spurious_rdy: cpu_rdy=1 dout=%0h with no read outstanding", bus.cpu_dout);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", {24'h0, bus.cpu_dout}, {24'h0, e});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the strobe was sampled
    task automatic strobe(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [7:0] d, input bit push);
        bus.cpu_rd   = rd;
        bus.cpu_wr   = wr;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
        if (wr) ref_mem[a] = d;
        else if (rd && push) exp_q.push_back(ref_rd(a));
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
    endtask

    task automatic settle(input string name);
        int k;
        k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (!(bus.cpu_wait == 1'b0 && bus.sd_req == bus.sd_ack && !ctl_busy
                     && exp_q.size() == 0) && k < 200);
        if (k >= 200) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: still busy after %0d cycles, wait=%0b queue=%0d", name, k,
                     bus.cpu_wait, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic rdy_lat(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.cpu_rdy && k < 100);
    endtask

    task automatic release_reset(input string name);
        int k;
        reset = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.cpu_wait !== 1'b0 && k < 20);
        chk({name, "_wait"}, {31'h0, bus.cpu_wait}, 32'h0);
        chk({name, "_aligned"}, {31'h0, bus.sd_req}, {31'h0, bus.sd_ack});
        @(posedge clk); #1;
        ctl_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        int   n0;
        int   lat;

        vecs[0] = '{1'b1, 1'b0, 16'h0200, 8'h00, 1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0201, 8'h00, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h0201, 8'h5A, 1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h0201, 8'h00, 0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0200, 8'h00, 0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0300, 8'h77, 1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 16'h0300, 8'h00, 1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 16'hFFFE, 8'hC3, 1, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 16'hFFFE, 8'h00, 0, 1'b0};

        mem[24'h000080]  = 16'hBEEF;
        ref_mem[16'h0100] = 8'hEF;
        ref_mem[16'h0101] = 8'hBE;

        bus.flush = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
        bus.cpu_addr = 16'h0; bus.cpu_din = 8'h0;
        bus2.cpu_rd = 1'b0; bus2.cpu_addr = 16'h0;

        // Reset values, then SYNC adopts ack=1
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sd_req", {31'h0, bus.sd_req}, 32'h0);
        chk("rst_cpu_wait", {31'h0, bus.cpu_wait}, 32'h1);
        chk("rst_cpu_rdy", {31'h0, bus.cpu_rdy}, 32'h0);
        chk("rst_cpu_dout", {24'h0, bus.cpu_dout}, 32'h0);
        chk("rst_sd_wr", {31'h0, bus.sd_wr}, 32'h0);
        chk("rst_sd_addr", {8'h0, bus.sd_addr}, 32'h0);
        chk("rst_sd_din", {16'h0, bus.sd_din}, 32'h0);
        chk("rst_sd_be", {30'h0, bus.sd_be}, 32'h0);
        @(posedge clk); #1;
        release_reset("sync");
        chk("sync_req_one", {31'h0, bus.sd_req}, 32'h1);

        // Word address wraps modulo 2^24 on the offset instance
        bus2.cpu_addr = 16'h0040;
        bus2.cpu_rd   = 1'b1;
        @(posedge clk); #1;
        bus2.cpu_rd = 1'b0;
        @(negedge clk);
        chk("wrap_sd_addr", {8'h0, bus2.sd_addr}, 32'h000010);
        chk("wrap_sd_be", {30'h0, bus2.sd_be}, 32'h3);
        chk("wrap_sd_req", {31'h0, bus2.sd_req}, 32'h1);
        @(posedge clk); #1;

        // Read miss: one toggle, latency LAT+2
        n0 = req_log.size();
        strobe(1'b1, 1'b0, 16'h0101, 8'h00, 1'b1);
        rdy_lat(lat);
        chk("miss_latency", lat, LAT + 2);
        settle("miss");
        chk("miss_reqs", req_log.size() - n0, 1);
        chk("miss_addr", {8'h0, req_log[n0].addr}, 32'h000080);
        chk("miss_be", {30'h0, req_log[n0].be}, 32'h3);
        chk("miss_wr", {31'h0, req_log[n0].wr}, 32'h0);

        // Read hit: 1 cycle, no toggle, no wait
        n0 = req_log.size();
        strobe(1'b1, 1'b0, 16'h0100, 8'h00, 1'b1);
        chk("hit_wait", {31'h0, bus.cpu_wait}, 32'h0);
        rdy_lat(lat);
        chk("hit_latency", lat, 1);
        chk("hit_wait_rdy", {31'h0, bus.cpu_wait}, 32'h0);
        settle("hit");
        chk("hit_reqs", req_log.size() - n0, 0);

        // Posted write with a read parked behind it
        n0 = req_log.size();
        strobe(1'b0, 1'b1, 16'h0100, 8'h12, 1'b0);
        chk("post_wait", {31'h0, bus.cpu_wait}, 32'h0);
        strobe(1'b1, 1'b0, 16'h0101, 8'h00, 1'b1);
        @(negedge clk);
        chk("b2b_wait", {31'h0, bus.cpu_wait}, 32'h1);
        @(posedge clk); #1;
        settle("b2b");
        chk("b2b_reqs", req_log.size() - n0, 1);
        chk("b2b_wr", {31'h0, req_log[n0].wr}, 32'h1);
        chk("b2b_be", {30'h0, req_log[n0].be}, 32'h1);
        chk("b2b_din", {16'h0, req_log[n0].din}, 32'h1212);
        chk("b2b_addr", {8'h0, req_log[n0].addr}, 32'h000080);
        n0 = req_log.size();
        strobe(1'b1, 1'b0, 16'h0100, 8'h00, 1'b1);
        settle("wt_hit");
        chk("wt_hit_reqs", req_log.size() - n0, 0);

        // Flush forces a refetch
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n0 = req_log.size();
        strobe(1'b1, 1'b0, 16'h0100, 8'h00, 1'b1);
        settle("flush_rd");
        chk("flush_reqs", req_log.size() - n0, 1);

        // rd+wr together: write only
        n0 = req_log.size();
        strobe(1'b1, 1'b1, 16'h0102, 8'h34, 1'b1);
        settle("rdwr");
        chk("rdwr_reqs", req_log.size() - n0, 1);
        chk("rdwr_wr", {31'h0, req_log[n0].wr}, 32'h1);
        chk("rdwr_din", {16'h0, req_log[n0].din}, 32'h3434);

        // Flush during a fill: data returned but not cached
        strobe(1'b1, 1'b0, 16'h0400, 8'h00, 1'b1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        settle("fill_flush");
        n0 = req_log.size();
        strobe(1'b1, 1'b0, 16'h0401, 8'h00, 1'b1);
        settle("fill_flush_rd");
        chk("fill_flush_reqs", req_log.size() - n0, 1);

        // Reset in the middle of a read miss
        strobe(1'b1, 1'b0, 16'h0500, 8'h00, 1'b0);
        @(posedge clk); #1;
        reset  = 1'b1;
        ctl_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_queue", exp_q.size(), 0);
        release_reset("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_idle", {31'h0, bus.sd_req}, {31'h0, bus.sd_ack});
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            n0 = req_log.size();
            strobe(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, 1'b1);
            settle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_reqs", i), req_log.size() - n0, vecs[i].reqs);
            if (vecs[i].reqs > 0)
                chk($sformatf("vec%0d_sd_wr", i), {31'h0, req_log[req_log.size()-1].wr},
                    {31'h0, vecs[i].last_wr});
        end

        chk("end_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
